// File: rtl/mult_add_sched.sv
// Round-robin scheduler sharing one external mult_add DSP among NUM_REQ requesters.
// Latency: result 1+DSP_LATENCY cycles after grant; no back-pressure on results, grants gated by en.
// Backpressure: req_ready grants at most one requester per cycle; results are never stalled.
module mult_add_sched #(
  parameter int NUM_REQ      = 4,
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48,
  parameter int DSP_LATENCY  = 1,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*A_DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]  req_c,
  output logic [A_DATA_WIDTH-1:0]          dsp_a,
  output logic [B_DATA_WIDTH-1:0]          dsp_b,
  output logic [C_DATA_WIDTH-1:0]          dsp_c,
  input  logic [P_DATA_WIDTH-1:0]          dsp_p,
  output logic                             res_valid,
  output logic [ID_W-1:0]                  res_id,
  output logic [P_DATA_WIDTH-1:0]          res_p,
  output logic                             busy
);

  localparam int STAGES = DSP_LATENCY + 1;

  logic [ID_W-1:0]              ptr;
  logic [ID_W-1:0]              ptr_nxt;
  logic [ID_W-1:0]              gnt_idx;
  logic [ID_W-1:0]              cand;
  logic                         gnt_found;
  logic                         grant;
  logic [STAGES-1:0]            tag_vld;
  logic [STAGES-1:0][ID_W-1:0]  tag_id;

  // Search upward from the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ((int'(ptr) + k) >= NUM_REQ) ? ID_W'(int'(ptr) + k - NUM_REQ)
                                          : ID_W'(int'(ptr) + k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant   = rst_n && en && gnt_found;
  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      dsp_a   <= '0;
      dsp_b   <= '0;
      dsp_c   <= '0;
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      if (grant) begin
        ptr   <= ptr_nxt;
        dsp_a <= req_a[gnt_idx*A_DATA_WIDTH +: A_DATA_WIDTH];
        dsp_b <= req_b[gnt_idx*B_DATA_WIDTH +: B_DATA_WIDTH];
        dsp_c <= req_c[gnt_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
      // Tags travel alongside the op so the last stage lines up with dsp_p.
      tag_vld <= {tag_vld[STAGES-2:0], grant};
      tag_id  <= {tag_id[STAGES-2:0], gnt_idx};
    end
  end

  assign res_valid = tag_vld[STAGES-1];
  assign res_id    = tag_id[STAGES-1];
  assign res_p     = dsp_p;
  assign busy      = |tag_vld;

endmodule

// File: tb/tb_mult_add_sched.sv
// Randomized + directed bench for mult_add_sched with a scoreboard and an external DSP model.
module tb_mult_add_sched;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int BW = 18;
  localparam int CW = 48;
  localparam int PW = 48;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N*CW-1:0] req_c = '0;
  logic [AW-1:0]   dsp_a;
  logic [BW-1:0]   dsp_b;
  logic [CW-1:0]   dsp_c;
  logic [PW-1:0]   dsp_p = '0;
  logic            res_valid;
  logic [1:0]      res_id;
  logic [PW-1:0]   res_p;
  logic            busy;

  mult_add_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_id(res_id), .res_p(res_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // External DSP: one output register (PREG only).
  always @(posedge clk)
    dsp_p <= PW'(longint'($signed(dsp_a)) * longint'($signed(dsp_b)) + longint'($signed(dsp_c)));

  typedef struct {
    int            acc;
    int            id;
    logic [PW-1:0] p;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mptr = 0;
  logic [AW-1:0] exp_da = '0;
  logic [BW-1:0] exp_db = '0;
  logic [CW-1:0] exp_dc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*AW-1:0] rnd_a();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  function automatic logic [N*BW-1:0] rnd_b();
    logic [N*BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  function automatic logic [N*CW-1:0] rnd_c();
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'({$urandom, $urandom});
    return r;
  endfunction

  // Reference: round-robin by modular search, result = a*b+c wrapped to PW bits.
  task automatic model_eval();
    int            g;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    exp_t          ne;
    g = -1;
    exp_rdy = '0;
    if (rst_n && en)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      a = req_a[g*AW +: AW];
      b = req_b[g*BW +: BW];
      c = req_c[g*CW +: CW];
      ne.acc = cyc;
      ne.id  = g;
      ne.p   = PW'(longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c)));
      q.push_back(ne);
      exp_da = a;
      exp_db = b;
      exp_dc = c;
      mptr = (g + 1) % N;
    end
  endtask

  task automatic step(input logic e, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*BW-1:0] b, input logic [N*CW-1:0] c);
    @(posedge clk);
    #1;
    chk("dsp_a", 64'(dsp_a), 64'(exp_da));
    chk("dsp_b", 64'(dsp_b), 64'(exp_db));
    chk("dsp_c", 64'(dsp_c), 64'(exp_dc));
    en = e;
    req_valid = v;
    req_a = a;
    req_b = b;
    req_c = c;
    #3;
    model_eval();
  endtask

  task automatic rstep(input logic e, input logic [N-1:0] v);
    step(e, v, rnd_a(), rnd_b(), rnd_c());
  endtask

  // Monitor: pops the scoreboard whenever a result is due or presented.
  exp_t e_mon;
  logic exp_busy;
  logic exp_rv;
  always @(negedge clk) begin
    exp_busy = (q.size() > 0) && (q[0].acc < cyc);
    exp_rv   = (q.size() > 0) && (q[0].acc + 2 <= cyc);
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("res_valid", 64'(res_valid), 64'(exp_rv));
    if ((res_valid || exp_rv) && q.size() > 0) begin
      e_mon = q.pop_front();
      if (res_valid) begin
        chk("res_latency", 64'(cyc), 64'(e_mon.acc + 2));
        chk("res_id", 64'(res_id), 64'(e_mon.id));
        chk("res_p", 64'(res_p), 64'(e_mon.p));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [N*AW-1:0] va;
  logic [N*BW-1:0] vb;
  logic [N*CW-1:0] vc;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    req_valid = '1;
    en = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_dsp_a", 64'(dsp_a), 64'(0));
    chk("rst_dsp_b", 64'(dsp_b), 64'(0));
    chk("rst_dsp_c", 64'(dsp_c), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_id", 64'(res_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    req_valid = '0;

    // Single op from requester 2 in the first cycle out of reset.
    va = rnd_a(); vb = rnd_b(); vc = rnd_c();
    va[2*AW +: AW] = AW'(3);
    vb[2*BW +: BW] = BW'(-4);
    vc[2*CW +: CW] = CW'(100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    req_valid = 4'b0100;
    req_a = va; req_b = vb; req_c = vc;
    #3;
    model_eval();
    rstep(1'b1, 4'b0000);
    rstep(1'b1, 4'b0000);
    @(negedge clk);
    #1;
    chk("single_res_valid", 64'(res_valid), 64'(1));
    chk("single_res_id", 64'(res_id), 64'(2));
    chk("single_res_p", 64'(res_p), 64'(88));

    // Wrap: pointer sits at 3 now.
    repeat (3) rstep(1'b1, 4'b1001);
    // Fairness.
    repeat (8) rstep(1'b1, 4'b1111);
    // en gating, then drain.
    repeat (3) rstep(1'b0, 4'b1111);
    repeat (3) rstep(1'b1, 4'b0000);
    // Requester drops without grant.
    rstep(1'b0, 4'b0100);
    rstep(1'b1, 4'b0000);
    // Single persistent requester.
    repeat (6) rstep(1'b1, 4'b0010);

    // Overflow wrap on requester 1.
    va = rnd_a(); vb = rnd_b(); vc = rnd_c();
    va[1*AW +: AW] = AW'(-(1 << 24));
    vb[1*BW +: BW] = BW'(-(1 << 17));
    vc[1*CW +: CW] = 48'h7FFF_FFFF_FFFF;
    step(1'b1, 4'b0010, va, vb, vc);
    rstep(1'b1, 4'b0000);
    rstep(1'b1, 4'b0000);
    @(negedge clk);
    #1;
    chk("ovf_res_id", 64'(res_id), 64'(1));
    chk("ovf_res_p", 64'(res_p), 64'(48'h81FF_FFFF_FFFF));

    // Random traffic.
    for (int i = 0; i < 400; i++)
      rstep(($urandom_range(0, 7) != 0), N'($urandom));

    // Reset mid-stream after two grants.
    repeat (2) rstep(1'b1, 4'b1111);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    mptr = 0;
    exp_da = '0; exp_db = '0; exp_dc = '0;
    #3;
    model_eval();
    rstep(1'b1, 4'b1111);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    req_valid = 4'b1111;
    req_a = rnd_a(); req_b = rnd_b(); req_c = rnd_c();
    #3;
    model_eval();
    repeat (5) rstep(1'b1, 4'b0000);

    chk("drain_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
